// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Instruction-cycle controller: PC, fetch handshake, IR load,
//            execute start and PC-relative branch.
// Revision : 1.0
// ============================================================================
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_in,
  input  logic        halt_req_in,
  output logic        mem_req_out,
  output logic [15:0] mem_addr_out,
  input  logic        mem_rdy_in,
  output logic        il_out,
  output logic        ex_start_out,
  input  logic        ex_done_in,
  input  logic        branch_in,
  input  logic [15:0] ia_in,
  output logic [15:0] pc_out,
  output logic        busy_out,
  output logic        halted_out,
  output logic        fault_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  // The last wait cycle that may still see mem_rdy_in before faulting.
  localparam logic [7:0] C_WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt;
  logic [7:0]  r_wait_cnt, w_wait_nxt;
  logic        r_halt_pend, w_halt_pend_nxt;
  logic        r_ex_start;
  logic        w_il;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_wait_cnt  <= 8'd0;
      r_halt_pend <= 1'b0;
      r_ex_start  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_halt_pend <= w_halt_pend_nxt;
      r_ex_start  <= (r_state == S_DECODE);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_wait_nxt      = 8'd0;
    w_halt_pend_nxt = r_halt_pend;
    w_il            = 1'b0;

    if (halt_req_in && (r_state == S_FETCH || r_state == S_DECODE || r_state == S_EXEC))
      w_halt_pend_nxt = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (run_in)
          w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (mem_rdy_in) begin
          w_il        = 1'b1;
          w_pc_nxt    = r_pc + 16'd1;
          w_state_nxt = S_DECODE;
        end else if (r_wait_cnt == C_WAIT_LAST) begin
          w_state_nxt = S_FAULT;
        end else begin
          w_wait_nxt = r_wait_cnt + 8'd1;
        end
      end
      S_DECODE: begin
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (ex_done_in) begin
          // Offset is relative to the already-incremented PC; 16-bit add wraps.
          if (branch_in)
            w_pc_nxt = r_pc + ia_in;
          if (r_halt_pend || halt_req_in) begin
            w_state_nxt     = S_HALT;
            w_halt_pend_nxt = 1'b0;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_HALT: begin
        if (run_in)
          w_state_nxt = S_FETCH;
      end
      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign mem_req_out  = (r_state == S_FETCH);
  assign mem_addr_out = r_pc;
  assign pc_out       = r_pc;
  assign il_out       = w_il;
  assign ex_start_out = r_ex_start;
  assign busy_out     = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC);
  assign halted_out   = (r_state == S_HALT);
  assign fault_out    = (r_state == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Self-checking bench for fetch_sequencer with a fetch-address scoreboard.
// Revision : 1.0
// ============================================================================
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run_in, halt_req_in, mem_rdy_in, ex_done_in, branch_in;
  logic [15:0] ia_in;
  logic        mem_req_out, il_out, ex_start_out, busy_out, halted_out, fault_out;
  logic [15:0] mem_addr_out, pc_out;
  logic        mem_req_b, il_b, ex_start_b, busy_b, halted_b, fault_b;
  logic [15:0] mem_addr_b, pc_b;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_fetch_q[$];
  logic [15:0] offs [4] = '{16'h000E, 16'hFFFC, 16'h0002, 16'h0005};
  logic [15:0] model_pc;

  fetch_sequencer #(.RESET_PC(16'h0000), .TIMEOUT(15)) u_dut (
    .clk(clk), .rst(rst), .run_in(run_in), .halt_req_in(halt_req_in),
    .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out), .mem_rdy_in(mem_rdy_in),
    .il_out(il_out), .ex_start_out(ex_start_out), .ex_done_in(ex_done_in),
    .branch_in(branch_in), .ia_in(ia_in), .pc_out(pc_out), .busy_out(busy_out),
    .halted_out(halted_out), .fault_out(fault_out)
  );

  fetch_sequencer #(.RESET_PC(16'hFFFF), .TIMEOUT(15)) u_dut_wrap (
    .clk(clk), .rst(rst), .run_in(run_in), .halt_req_in(halt_req_in),
    .mem_req_out(mem_req_b), .mem_addr_out(mem_addr_b), .mem_rdy_in(mem_rdy_in),
    .il_out(il_b), .ex_start_out(ex_start_b), .ex_done_in(ex_done_in),
    .branch_in(branch_in), .ia_in(ia_in), .pc_out(pc_b), .busy_out(busy_b),
    .halted_out(halted_b), .fault_out(fault_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every IR load must match the next address the stimulus expects to be fetched.
  always @(negedge clk) begin
    if (!rst && il_out) begin
      if (exp_fetch_q.size() == 0)
        check("fetch_unexpected", {16'd0, mem_addr_out}, 32'h0001_0000);
      else
        check("fetch_addr", {16'd0, mem_addr_out}, {16'd0, exp_fetch_q.pop_front()});
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    run_in      = 1'b0;
    halt_req_in = 1'b0;
    mem_rdy_in  = 1'b0;
    ex_done_in  = 1'b0;
    branch_in   = 1'b0;
    ia_in       = 16'h0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    sample();
    check("rst_flags", {26'd0, mem_req_out, il_out, ex_start_out, busy_out, halted_out, fault_out}, 32'd0);
    check("rst_pc", pc_out, 32'h0000);
    check("rst_addr", mem_addr_out, 32'h0000);
    check("rst_pc_wrapdut", pc_b, 32'hFFFF);
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;

    // Back-to-back instructions with zero wait states
    do_reset();
    run_in = 1'b1; mem_rdy_in = 1'b1; ex_done_in = 1'b1;
    for (int i = 0; i < 4; i++) exp_fetch_q.push_back(16'(i));
    next_cycle();
    run_in = 1'b0;
    for (int c = 0; c < 12; c++) begin
      sample();
      check($sformatf("t1_il_c%0d", c), {31'd0, il_out}, {31'd0, (c % 3) == 0});
      check($sformatf("t1_exstart_c%0d", c), {31'd0, ex_start_out}, {31'd0, (c % 3) == 2});
      check($sformatf("t1_busy_c%0d", c), {31'd0, busy_out}, 32'd1);
      if (c == 0) check("t5_addr_before_wrap", mem_addr_b, 32'hFFFF);
      if (c == 1) begin
        check("t5_pc_wrap", pc_b, 32'h0000);
        check("t5_addr_wrap", mem_addr_b, 32'h0000);
      end
      next_cycle();
    end
    mem_rdy_in = 1'b0; ex_done_in = 1'b0;
    sample();
    check("t1_sb_drained", exp_fetch_q.size(), 32'd0);

    // Fetch timeout: 15 FETCH cycles without ready
    do_reset();
    run_in = 1'b1;
    next_cycle();
    run_in = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      sample();
      check($sformatf("t2_wait_k%0d", k), {30'd0, mem_req_out, fault_out}, 32'b10);
      next_cycle();
    end
    sample();
    check("t2_fault", {28'd0, fault_out, mem_req_out, busy_out, halted_out}, 32'b1000);
    run_in = 1'b1; mem_rdy_in = 1'b1; ex_done_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      sample();
      check($sformatf("t2_sticky_k%0d", k), {28'd0, fault_out, mem_req_out, il_out, ex_start_out}, 32'b1000);
    end

    // Ready arriving on the last permitted wait cycle
    do_reset();
    run_in = 1'b1;
    next_cycle();
    run_in = 1'b0;
    for (int k = 1; k <= 14; k++) next_cycle();
    mem_rdy_in = 1'b1;
    exp_fetch_q.push_back(16'h0000);
    sample();
    check("t2v_il", {30'd0, il_out, fault_out}, 32'b10);
    next_cycle();
    mem_rdy_in = 1'b0;
    sample();
    check("t2v_nofault", {30'd0, busy_out, fault_out}, 32'b10);

    // PC-relative branches, backward and forward
    do_reset();
    mem_rdy_in = 1'b1; ex_done_in = 1'b1; branch_in = 1'b1;
    model_pc = 16'h0000;
    run_in = 1'b1;
    next_cycle();
    run_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ia_in = offs[i];
      exp_fetch_q.push_back(model_pc);
      model_pc = model_pc + 16'd1 + offs[i];
      sample();
      check($sformatf("t3_il_i%0d", i), {31'd0, il_out}, 32'd1);
      next_cycle();
      next_cycle();
      sample();
      check($sformatf("t3_exstart_i%0d", i), {31'd0, ex_start_out}, 32'd1);
      if (i == 3) mem_rdy_in = 1'b0;
      next_cycle();
    end
    sample();
    check("t3_final_addr", mem_addr_out, 32'h0015);
    check("t3_final_pc", pc_out, {16'd0, model_pc});
    branch_in = 1'b0;

    // Halt: ignored in IDLE, honoured from a one-cycle pulse in FETCH
    do_reset();
    halt_req_in = 1'b1;
    next_cycle();
    halt_req_in = 1'b0;
    run_in = 1'b1; mem_rdy_in = 1'b1; ex_done_in = 1'b1;
    exp_fetch_q.push_back(16'h0000);
    exp_fetch_q.push_back(16'h0001);
    next_cycle();
    run_in = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    halt_req_in = 1'b1;
    sample();
    check("t4_idle_halt_ignored", {30'd0, halted_out, busy_out}, 32'b01);
    next_cycle();
    halt_req_in = 1'b0;
    next_cycle();
    next_cycle();
    sample();
    check("t4_halted", {29'd0, halted_out, busy_out, mem_req_out}, 32'b100);
    check("t4_pc_held", pc_out, 32'h0002);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      sample();
      check($sformatf("t4_stay_k%0d", k), {15'd0, halted_out, pc_out}, 32'h1_0002);
    end
    run_in = 1'b1;
    exp_fetch_q.push_back(16'h0002);
    next_cycle();
    run_in = 1'b0;
    sample();
    check("t4_resume", {30'd0, halted_out, il_out}, 32'b01);
    next_cycle();
    mem_rdy_in = 1'b0;

    // Asynchronous reset in the middle of EXEC
    do_reset();
    run_in = 1'b1; mem_rdy_in = 1'b1;
    exp_fetch_q.push_back(16'h0000);
    next_cycle();
    run_in = 1'b0;
    next_cycle();
    mem_rdy_in = 1'b0;
    next_cycle();
    sample();
    check("t6_in_exec", {14'd0, ex_start_out, busy_out, pc_out}, 32'h3_0001);
    #2 rst = 1'b1;
    #1;
    check("t6_async_flags", {26'd0, mem_req_out, il_out, ex_start_out, busy_out, halted_out, fault_out}, 32'd0);
    check("t6_async_pc", {mem_addr_out, pc_out}, 32'h0000_0000);
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sample();
      check($sformatf("t6_idle_k%0d", k), {14'd0, busy_out, mem_req_out, pc_out}, 32'h0);
      next_cycle();
    end
    run_in = 1'b1; mem_rdy_in = 1'b1;
    exp_fetch_q.push_back(16'h0000);
    next_cycle();
    run_in = 1'b0;
    sample();
    check("t6_refetch", {31'd0, il_out}, 32'd1);
    next_cycle();
    mem_rdy_in = 1'b0;

    sample();
    check("sb_drained", exp_fetch_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
